// File: rtl/imem_dmem_arbiter_if.sv
// Bus bundle between the core's fetch/load-store ports, the arbiter and the
// shared single-port RAM. The arbiter takes the slave view. The core and RAM
// side takes the master view.
interface imem_dmem_arbiter_if #(
    parameter int ADDR_W = 21
);
    // Instruction-fetch port
    logic              f_req;
    logic [31:0]       f_addr;
    logic              f_gnt;
    logic [31:0]       f_rdata;
    logic              f_rvalid;

    // Load/store port
    logic              d_req;
    logic [3:0]        d_wmask;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic [31:0]       d_rdata;
    logic              d_rvalid;

    // Shared RAM port
    logic              ram_en;
    logic [3:0]        ram_wmask;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;

    modport slave (
        input  f_req, f_addr,
        output f_gnt, f_rdata, f_rvalid,
        input  d_req, d_wmask, d_addr, d_wdata,
        output d_gnt, d_rdata, d_rvalid,
        output ram_en, ram_wmask, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output f_req, f_addr,
        input  f_gnt, f_rdata, f_rvalid,
        output d_req, d_wmask, d_addr, d_wdata,
        input  d_gnt, d_rdata, d_rvalid,
        input  ram_en, ram_wmask, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one single-port synchronous RAM between instruction fetch and
// load/store. Data wins by default because it belongs to the older
// instruction. A streak counter forces fetch through after MAX_STREAK
// back-to-back data wins while fetch waits. Read data returns one cycle
// after grant and is held until the next read for that requester completes.
module imem_dmem_arbiter #(
    parameter int          ADDR_W     = 21,
    parameter int          MAX_STREAK = 4,
    parameter logic [31:0] NOP_WORD   = 32'h0000_0033
) (
    input  logic                clk,
    input  logic                resetn,
    imem_dmem_arbiter_if.slave  bus,
    output logic [31:0]         stat_fwait
);
    // The counter must hold 0..MAX_STREAK. Keep at least one bit when MAX_STREAK is 0.
    localparam int STREAK_W = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] r_streak;
    logic                r_f_pend;
    logic                r_d_pend;
    logic [31:0]         r_f_hold;
    logic [31:0]         r_d_hold;
    logic [31:0]         r_stat_fwait;

    logic                w_force_f;
    logic                w_d_gnt;
    logic                w_f_gnt;
    logic                w_d_read;
    logic [3:0]          w_ram_wmask;

    // Grants are qualified by resetn so that the RAM stays idle while reset is asserted.
    assign w_force_f = (MAX_STREAK != 0) && (r_streak == STREAK_MAX);
    assign w_d_gnt   = resetn & bus.d_req & ~(bus.f_req & w_force_f);
    assign w_f_gnt   = resetn & bus.f_req & ~w_d_gnt;
    assign w_d_read  = w_d_gnt & (bus.d_wmask == 4'b0000);

    assign bus.d_gnt = w_d_gnt;
    assign bus.f_gnt = w_f_gnt;

    // Only a granted data access can write. Mask each lane with the data grant.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign w_ram_wmask[gi] = w_d_gnt & bus.d_wmask[gi];
        end
    endgenerate

    assign bus.ram_en    = w_f_gnt | w_d_gnt;
    assign bus.ram_wmask = w_ram_wmask;
    assign bus.ram_addr  = w_d_gnt ? bus.d_addr[ADDR_W+1:2] : bus.f_addr[ADDR_W+1:2];
    assign bus.ram_wdata = w_d_gnt ? bus.d_wdata : 32'h0000_0000;

    // Return the fresh RAM word in the cycle after a read grant. Otherwise return the held word.
    assign bus.f_rvalid = r_f_pend;
    assign bus.f_rdata  = r_f_pend ? bus.ram_rdata : r_f_hold;
    assign bus.d_rvalid = r_d_pend;
    assign bus.d_rdata  = r_d_pend ? bus.ram_rdata : r_d_hold;
    assign stat_fwait   = r_stat_fwait;

    // Track outstanding reads and latch returned words for each requester.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_f_pend <= 1'b0;
            r_d_pend <= 1'b0;
            r_f_hold <= NOP_WORD;
            r_d_hold <= 32'h0000_0000;
        end else begin
            r_f_pend <= w_f_gnt;
            r_d_pend <= w_d_read;
            if (r_f_pend) r_f_hold <= bus.ram_rdata;
            if (r_d_pend) r_d_hold <= bus.ram_rdata;
        end
    end

    // Count data wins while fetch waits (saturating). Clear the count when fetch gets in or stops asking.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_streak <= '0;
        end else if (w_d_gnt && bus.f_req) begin
            if (r_streak != STREAK_MAX) r_streak <= r_streak + STREAK_W'(1);
        end else begin
            r_streak <= '0;
        end
    end

    // Count fetch stall cycles. The counter wraps at 2^32.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stat_fwait <= 32'h0000_0000;
        end else if (bus.f_req && !w_f_gnt) begin
            r_stat_fwait <= r_stat_fwait + 32'd1;
        end
    end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter. Instance A uses MAX_STREAK=4 and instance B uses MAX_STREAK=0.
// Each instance has its own behavioural 1-cycle-latency RAM.
module tb_imem_dmem_arbiter;
    logic        clk;
    logic        resetn;
    logic [31:0] stat_a;
    logic [31:0] stat_b;
    int          total;
    int          bad;
    logic [31:0] exp_stat;

    imem_dmem_arbiter_if #(.ADDR_W(21)) bus_a ();
    imem_dmem_arbiter_if #(.ADDR_W(21)) bus_b ();

    imem_dmem_arbiter #(.ADDR_W(21), .MAX_STREAK(4), .NOP_WORD(32'h0000_0033)) dut_a (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus_a),
        .stat_fwait (stat_a)
    );

    imem_dmem_arbiter #(.ADDR_W(21), .MAX_STREAK(0), .NOP_WORD(32'h0000_0033)) dut_b (
        .clk        (clk),
        .resetn     (resetn),
        .bus        (bus_b),
        .stat_fwait (stat_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];

    // RAM model A: byte-masked write, read-first, 1-cycle read latency
    always @(posedge clk) begin
        if (bus_a.ram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus_a.ram_wmask[b]) mem_a[bus_a.ram_addr[7:0]][8*b +: 8] <= bus_a.ram_wdata[8*b +: 8];
            bus_a.ram_rdata <= mem_a[bus_a.ram_addr[7:0]];
        end
    end

    // RAM model B
    always @(posedge clk) begin
        if (bus_b.ram_en) begin
            for (int b = 0; b < 4; b++)
                if (bus_b.ram_wmask[b]) mem_b[bus_b.ram_addr[7:0]][8*b +: 8] <= bus_b.ram_wdata[8*b +: 8];
            bus_b.ram_rdata <= mem_b[bus_b.ram_addr[7:0]];
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] <= 32'hA000_0000 | 32'(i);
            mem_b[i] <= 32'hA000_0000 | 32'(i);
        end
        mem_a[0]    <= 32'h0000_0011;
        mem_a[1]    <= 32'h0000_0022;
        mem_a[2]    <= 32'h0000_0033;
        mem_a[16]   <= 32'hDEAD_BEEF;
        mem_a[64]   <= 32'h1234_5678;
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic idle_a();
        bus_a.f_req = 1'b0; bus_a.f_addr = 32'h0;
        bus_a.d_req = 1'b0; bus_a.d_wmask = 4'h0; bus_a.d_addr = 32'h0; bus_a.d_wdata = 32'h0;
    endtask

    task automatic idle_b();
        bus_b.f_req = 1'b0; bus_b.f_addr = 32'h0;
        bus_b.d_req = 1'b0; bus_b.d_wmask = 4'h0; bus_b.d_addr = 32'h0; bus_b.d_wdata = 32'h0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        resetn = 1'b0;
        idle_a();
        idle_b();

        // Reset: requests present but all grants and RAM enable forced low
        bus_a.f_req = 1'b1; bus_a.d_req = 1'b1; bus_a.d_addr = 32'h40;
        repeat (2) @(posedge clk);
        smp();
        chk1 ("rst_f_gnt",    bus_a.f_gnt,    1'b0);
        chk1 ("rst_d_gnt",    bus_a.d_gnt,    1'b0);
        chk1 ("rst_ram_en",   bus_a.ram_en,   1'b0);
        chk1 ("rst_f_rvalid", bus_a.f_rvalid, 1'b0);
        chk1 ("rst_d_rvalid", bus_a.d_rvalid, 1'b0);
        chk32("rst_f_rdata",  bus_a.f_rdata,  32'h0000_0033);
        chk32("rst_d_rdata",  bus_a.d_rdata,  32'h0000_0000);
        chk32("rst_stat",     stat_a,         32'd0);
        $display("txn reset: checked idle outputs");
        cyc(); resetn = 1'b1; idle_a();

        // Fetch-only stream: words 0x11, 0x22, 0x33
        cyc(); bus_a.f_req = 1'b1; bus_a.f_addr = 32'h0;
        smp();
        chk1 ("fs0_f_gnt",    bus_a.f_gnt,    1'b1);
        chk1 ("fs0_ram_en",   bus_a.ram_en,   1'b1);
        chk32("fs0_ram_addr", {11'b0, bus_a.ram_addr}, 32'h0);
        chk32("fs0_ram_wmask",{28'b0, bus_a.ram_wmask}, 32'h0);
        chk1 ("fs0_f_rvalid", bus_a.f_rvalid, 1'b0);
        cyc(); bus_a.f_addr = 32'h4;
        smp();
        chk1 ("fs1_f_gnt",    bus_a.f_gnt,    1'b1);
        chk32("fs1_ram_addr", {11'b0, bus_a.ram_addr}, 32'h1);
        chk1 ("fs1_f_rvalid", bus_a.f_rvalid, 1'b1);
        chk32("fs1_f_rdata",  bus_a.f_rdata,  32'h0000_0011);
        cyc(); bus_a.f_addr = 32'h8;
        smp();
        chk1 ("fs2_f_gnt",    bus_a.f_gnt,    1'b1);
        chk32("fs2_f_rdata",  bus_a.f_rdata,  32'h0000_0022);
        cyc(); bus_a.f_req = 1'b0;
        smp();
        chk1 ("fs3_ram_en",   bus_a.ram_en,   1'b0);
        chk1 ("fs3_f_rvalid", bus_a.f_rvalid, 1'b1);
        chk32("fs3_f_rdata",  bus_a.f_rdata,  32'h0000_0033);
        chk32("fs3_stat",     stat_a,         32'd0);
        $display("txn fetch stream: 3 words");

        // Conflict: data read at 0x40 wins, fetch of word 3 follows
        cyc(); bus_a.f_req = 1'b1; bus_a.f_addr = 32'hC; bus_a.d_req = 1'b1; bus_a.d_addr = 32'h40;
        smp();
        chk1 ("cf0_d_gnt",    bus_a.d_gnt,    1'b1);
        chk1 ("cf0_f_gnt",    bus_a.f_gnt,    1'b0);
        chk32("cf0_ram_addr", {11'b0, bus_a.ram_addr}, 32'h10);
        cyc(); bus_a.d_req = 1'b0;
        smp();
        chk1 ("cf1_d_rvalid", bus_a.d_rvalid, 1'b1);
        chk32("cf1_d_rdata",  bus_a.d_rdata,  32'hDEAD_BEEF);
        chk1 ("cf1_f_gnt",    bus_a.f_gnt,    1'b1);
        chk32("cf1_ram_addr", {11'b0, bus_a.ram_addr}, 32'h3);
        chk32("cf1_stat",     stat_a,         32'd1);
        cyc(); bus_a.f_req = 1'b0;
        smp();
        chk1 ("cf2_f_rvalid", bus_a.f_rvalid, 1'b1);
        chk32("cf2_f_rdata",  bus_a.f_rdata,  32'hA000_0003);
        chk1 ("cf2_d_rvalid", bus_a.d_rvalid, 1'b0);
        chk32("cf2_d_rdata",  bus_a.d_rdata,  32'hDEAD_BEEF);
        $display("txn conflict: data first, then fetch");

        // Byte write to lane 2 of word 0x40, then read back
        cyc(); bus_a.d_req = 1'b1; bus_a.d_wmask = 4'b0100; bus_a.d_addr = 32'h102; bus_a.d_wdata = 32'h00AB_0000;
        smp();
        chk1 ("wr0_d_gnt",    bus_a.d_gnt,    1'b1);
        chk32("wr0_ram_wmask",{28'b0, bus_a.ram_wmask}, 32'h4);
        chk32("wr0_ram_addr", {11'b0, bus_a.ram_addr}, 32'h40);
        chk32("wr0_ram_wdata",bus_a.ram_wdata, 32'h00AB_0000);
        cyc(); bus_a.d_wmask = 4'b0000; bus_a.d_addr = 32'h100; bus_a.d_wdata = 32'h0;
        smp();
        chk1 ("wr1_d_rvalid", bus_a.d_rvalid, 1'b0);
        chk32("wr1_ram_wmask",{28'b0, bus_a.ram_wmask}, 32'h0);
        cyc(); bus_a.d_req = 1'b0;
        smp();
        chk1 ("wr2_d_rvalid", bus_a.d_rvalid, 1'b1);
        chk32("wr2_d_rdata",  bus_a.d_rdata,  32'h12AB_5678);
        $display("txn byte write + readback");

        // Starvation guard: both held for 12 cycles -> D,D,D,D,F repeating
        exp_stat = 32'd1;
        cyc(); bus_a.f_req = 1'b1; bus_a.f_addr = 32'h20; bus_a.d_req = 1'b1; bus_a.d_addr = 32'h44;
        for (int c = 0; c < 12; c++) begin
            if (c > 0) cyc();
            smp();
            chk1 ("sv_f_gnt",    bus_a.f_gnt,    (c % 5) == 4);
            chk1 ("sv_d_gnt",    bus_a.d_gnt,    (c % 5) != 4);
            chk1 ("sv_f_rvalid", bus_a.f_rvalid, (c > 0) && ((c % 5) == 0));
            chk1 ("sv_d_rvalid", bus_a.d_rvalid, (c > 0) && ((c % 5) != 0));
            chk32("sv_f_rdata",  bus_a.f_rdata,  (c < 5) ? 32'hA000_0003 : 32'hA000_0008);
            chk32("sv_d_rdata",  bus_a.d_rdata,  (c == 0) ? 32'h12AB_5678 : 32'hA000_0011);
            chk32("sv_stat",     stat_a,         exp_stat);
            $display("txn starve c=%0d f_gnt=%b d_gnt=%b stat=%0d", c, bus_a.f_gnt, bus_a.d_gnt, stat_a);
            if ((c % 5) != 4) exp_stat = exp_stat + 32'd1;
        end
        cyc(); idle_a();
        smp();
        chk1 ("sv_end_f_rvalid", bus_a.f_rvalid, 1'b0);
        chk32("sv_end_stat",     stat_a,         32'd11);

        // Reset asserted the cycle after a fetch grant: the in-flight read is dropped
        cyc(); bus_a.f_req = 1'b1; bus_a.f_addr = 32'h24;
        smp();
        chk1 ("rf_f_gnt", bus_a.f_gnt, 1'b1);
        cyc(); resetn = 1'b0;
        smp();
        chk1 ("rf_f_rvalid", bus_a.f_rvalid, 1'b0);
        chk32("rf_f_rdata",  bus_a.f_rdata,  32'h0000_0033);
        chk32("rf_d_rdata",  bus_a.d_rdata,  32'h0000_0000);
        chk32("rf_stat",     stat_a,         32'd0);
        chk1 ("rf_ram_en0",  bus_a.ram_en,   1'b0);
        chk1 ("rf_f_gnt0",   bus_a.f_gnt,    1'b0);
        cyc();
        smp();
        chk1 ("rf_ram_en1",  bus_a.ram_en,   1'b0);
        chk32("rf_stat1",    stat_a,         32'd0);
        cyc(); resetn = 1'b1; bus_a.f_req = 1'b0;
        smp();
        chk1 ("rf_post_f_rvalid", bus_a.f_rvalid, 1'b0);
        chk32("rf_post_f_rdata",  bus_a.f_rdata,  32'h0000_0033);
        $display("txn reset after fetch grant");

        // Streak is cleared by reset: build streak=2, reset, expect D,D,D,D,F afterwards
        cyc(); bus_a.f_req = 1'b1; bus_a.f_addr = 32'h20; bus_a.d_req = 1'b1; bus_a.d_addr = 32'h44;
        smp();
        chk1 ("sr_pre0_d_gnt", bus_a.d_gnt, 1'b1);
        cyc();
        smp();
        chk1 ("sr_pre1_d_gnt", bus_a.d_gnt, 1'b1);
        cyc(); resetn = 1'b0;
        smp();
        chk1 ("sr_rst_ram_en",   bus_a.ram_en,   1'b0);
        chk1 ("sr_rst_d_rvalid", bus_a.d_rvalid, 1'b0);
        cyc(); resetn = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c > 0) cyc();
            smp();
            chk1("sr_f_gnt", bus_a.f_gnt, c == 4);
            if (c == 0) chk1("sr_d_rvalid0", bus_a.d_rvalid, 1'b0);
            $display("txn streak-after-reset c=%0d f_gnt=%b", c, bus_a.f_gnt);
        end
        cyc(); idle_a();

        // MAX_STREAK=0: data wins all 8 cycles
        bus_b.f_req = 1'b1; bus_b.f_addr = 32'h0; bus_b.d_req = 1'b1; bus_b.d_addr = 32'h40;
        for (int c = 0; c < 8; c++) begin
            if (c > 0) cyc();
            smp();
            chk1("m0_d_gnt", bus_b.d_gnt, 1'b1);
            chk1("m0_f_gnt", bus_b.f_gnt, 1'b0);
            $display("txn max0 c=%0d d_gnt=%b f_gnt=%b", c, bus_b.d_gnt, bus_b.f_gnt);
        end
        cyc(); idle_b();
        smp();
        chk32("m0_stat",     stat_b,         32'd8);
        chk1 ("m0_d_rvalid", bus_b.d_rvalid, 1'b1);
        chk32("m0_d_rdata",  bus_b.d_rdata,  32'hA000_0010);
        chk32("m0_f_rdata",  bus_b.f_rdata,  32'h0000_0033);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
